// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-schedule FSM state type and round-constant lookup.
package aes_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_BLK  = 128;
    localparam int AES_RK_W = 1408;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry 0 sits in the top byte, so entry a lives at byte offset 255-a == ~a.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb8145ede0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slot register file.
//   state     | meaning
//   ST_IDLE   | after reset, nothing loaded
//   ST_EXPAND | generating slot rnd from slot rnd-1
//   ST_DONE   | all eleven slots valid and held
module aes_key_expansion_seq
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  kld,
    input  logic [AES_BLK-1:0]    key_in,
    output logic [0:AES_RK_W-1]   round_keys,
    output logic                  keys_valid,
    output logic                  busy
);

    ks_state_e          state;
    logic [3:0]         rnd;
    logic [AES_BLK-1:0] slot [0:AES_NR];

    logic [AES_BLK-1:0] prev_key;
    logic [AES_BLK-1:0] next_key;
    logic [31:0]        rot_w;
    logic [31:0]        sub_w;
    logic [31:0]        t_w;
    logic [31:0]        n0, n1, n2, n3;

    // Single shared round step; rnd always points at the slot being written.
    assign prev_key = slot[rnd - 4'd1];
    assign rot_w    = {prev_key[23:0], prev_key[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .a (rot_w[8*b +: 8]),
            .y (sub_w[8*b +: 8])
        );
    end

    assign t_w      = sub_w ^ {rcon(rnd), 24'h0};
    assign n0       = prev_key[127:96] ^ t_w;
    assign n1       = prev_key[95:64]  ^ n0;
    assign n2       = prev_key[63:32]  ^ n1;
    assign n3       = prev_key[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rnd        <= 4'd0;
            keys_valid <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i <= AES_NR; i++) slot[i] <= '0;
        end else if (kld) begin
            slot[0]    <= key_in;
            rnd        <= 4'd1;
            state      <= ST_EXPAND;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                ST_EXPAND: begin
                    slot[rnd] <= next_key;
                    if (rnd == 4'(NR)) begin
                        state      <= ST_DONE;
                        keys_valid <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot i occupies [128*i : 128*i+127] with its MSB at the lowest index.
    for (genvar s = 0; s <= AES_NR; s++) begin : g_pack
        assign round_keys[AES_BLK*s +: AES_BLK] = slot[s];
    end

endmodule

// File: doc/aes_key_expansion_seq.md
# aes_key_expansion_seq

Iterative AES-128 key schedule that sits directly upstream of the unrolled decryption datapath. It loads a 128-bit cipher key and generates the ten round keys, one per clock. It then holds all eleven keys as a flat 1408-bit vector in the slot order the decryption datapath consumes. The downstream datapath may use `round_keys` only while `keys_valid` is high.

## Interface

Parameters:
- `NR`, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `kld`  in  1  key-load strobe; samples `key_in` and starts expansion
- `key_in`  in  128  cipher key, bit 127 = first key byte MSB
- `round_keys`  out  [0:1407]  slot i at [128*i : 128*i+127]; slot 0 = cipher key, slot 10 = final round key; bit 128*i is the MSB of slot i
- `keys_valid`  out  1  all 11 slots hold a complete, consistent schedule
- `busy`  out  1  expansion in progress

## Operation

- FSM states: IDLE, EXPAND, DONE.
- IDLE (after reset): `keys_valid`=0, `busy`=0, `round_keys` all zero.
- `kld`=1 in any state, sampled on edge E0:
  - slot 0 <= `key_in`; round counter <= 1; state <= EXPAND.
  - `keys_valid` <= 0; `busy` <= 1.
- EXPAND, edge Ei (i = 1..10): slot i <= next(slot i-1), where w0..w3 are the 32-bit words of slot i-1, MSB word first:
  - t = SubWord(RotWord(w3)) ^ {Rcon[i], 24'h0}
  - n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 (GF(2^8), no arithmetic carry)
- On E10: state <= DONE, `keys_valid` <= 1, `busy` <= 0.
- DONE: all slots held; `kld` restarts the sequence.
- `kld` during EXPAND: restart from the new key at that edge. Previous partial slots may remain but are don't-care; `keys_valid` stays 0.
- `kld` held high for several cycles: each high edge reloads, so expansion begins from the last high edge.
- Stale slots 1..10 are not cleared on reload. Consumers rely only on `keys_valid`.

## Timing

- Latency: `kld` sampled at E0 -> `keys_valid` high after E10, i.e. 10 cycles later.
- Throughput: one new schedule per 11 cycles if `kld` is pulsed every 11th cycle (reload at the edge after E10 is legal).
- All outputs are registered. No combinational path from inputs to outputs.
- Reset asserted mid-expansion: immediately IDLE; `round_keys`=0, `keys_valid`=0, `busy`=0.
- `kld` is ignored while `reset` is high.
- Critical path per cycle: one S-box lookup plus five 32-bit XOR levels.

## Structure

- Shared package `aes_pkg`:
  - `AES_NR`=10, `AES_BLK`=128, `AES_RK_W`=1408
  - Rcon table as a constant function `rcon(i)`
  - FSM state enum typedef
- Sub-module `aes_sbox`: combinational forward S-box, 8-bit in/out, instantiated 4x for SubWord.
- Single shared round-step datapath feeding a slot-indexed register file.

## Test plan

- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `kld` pulse:
  - after 10 cycles `keys_valid`=1
  - slot 1 = `a0fafe1788542cb123a339392a6c7605`
  - slot 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`
- All-zero key:
  - slot 1 = `62636363626363636263636362636363`
  - slot 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`
- Reload during EXPAND:
  - start zero key, pulse `kld` with the FIPS key 4 cycles later
  - `keys_valid` stays 0 until 10 cycles after the second pulse
  - slot 10 = `d014f9a8...0ca6`
- Reset asserted at cycle 5 of expansion:
  - all outputs 0 the same cycle, asynchronously
  - after deassertion, stays in IDLE with no `kld`
- End-to-end: drive `round_keys` into the decryption datapath with the FIPS key and ciphertext `3925841d02dc09fbdc118597196a0b32`:
  - output equals `3243f6a8885a308d313198a2e0370734`
- Back-to-back `kld` at the edge after E10:
  - `keys_valid` drops for exactly 10 cycles
  - new schedule is correct
